// File: rtl/bounce_gen_if.sv
// Button-emulator signal bundle: requested level in, noisy button and status out.
interface bounce_gen_if;
  logic       press;
  logic       btn;
  logic       busy;
  logic [7:0] edge_cnt;

  // master drives the requested level; slave is the emulator itself
  modport master (output press, input btn, input busy, input edge_cnt);
  modport slave  (input press, output btn, output busy, output edge_cnt);
endinterface

// File: rtl/bounce_gen.sv
// Mechanical-switch emulator: on a level request, emits 2*BOUNCES+1 edges spaced
// by LFSR-randomized gaps, ending at the requested level.
module bounce_gen #(
  parameter int unsigned MIN_GAP  = 200,
  parameter int unsigned GAP_BITS = 10,
  parameter int unsigned BOUNCES  = 4,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input logic         clk,
  input logic         rst,
  bounce_gen_if.slave bus
);

  localparam int unsigned EDGES = 2 * BOUNCES + 1;
  localparam int unsigned GW    = $clog2(MIN_GAP + (1 << GAP_BITS));
  localparam int unsigned SW    = $clog2(EDGES + 1);

  typedef enum logic {STABLE, BOUNCE} state_t;

  state_t        state, state_n;
  logic [15:0]   lfsr, lfsr_n;
  logic [GW-1:0] gap, gap_n, gap_load;
  logic [SW-1:0] seq, seq_n, seq_inc;
  logic          btn, btn_n;
  logic          busy, busy_n;
  logic [7:0]    edge_cnt, edge_cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= STABLE;
      lfsr     <= SEED;
      gap      <= '0;
      seq      <= '0;
      btn      <= 1'b0;
      busy     <= 1'b0;
      edge_cnt <= 8'd0;
    end else begin
      state    <= state_n;
      lfsr     <= lfsr_n;
      gap      <= gap_n;
      seq      <= seq_n;
      btn      <= btn_n;
      busy     <= busy_n;
      edge_cnt <= edge_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    gap_n      = gap;
    seq_n      = seq;
    btn_n      = btn;
    busy_n     = busy;
    edge_cnt_n = edge_cnt;
    seq_inc    = seq + SW'(1);
    lfsr_n     = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    // counter holds G-1 so consecutive edges land exactly G cycles apart
    gap_load   = GW'(MIN_GAP) + GW'(lfsr[GAP_BITS-1:0]) - GW'(1);

    case (state)
      STABLE: begin
        busy_n = 1'b0;
        if (bus.press != btn) begin
          btn_n      = ~btn;
          edge_cnt_n = edge_cnt + 8'd1;
          seq_n      = SW'(1);
          if (BOUNCES != 0) begin
            gap_n   = gap_load;
            state_n = BOUNCE;
            busy_n  = 1'b1;
          end
        end
      end
      BOUNCE: begin
        busy_n = 1'b1;
        if (gap != '0) begin
          gap_n = gap - GW'(1);
        end else begin
          btn_n      = ~btn;
          edge_cnt_n = edge_cnt + 8'd1;
          seq_n      = seq_inc;
          if (seq_inc == SW'(EDGES)) begin
            state_n = STABLE;
            busy_n  = 1'b0;
          end else begin
            gap_n = gap_load;
          end
        end
      end
      default: state_n = STABLE;
    endcase
  end

  assign bus.btn      = btn;
  assign bus.busy     = busy;
  assign bus.edge_cnt = edge_cnt;

endmodule

// File: tb/tb_bounce_gen.sv
// Self-checking bench for bounce_gen: edge timing is predicted from an LFSR
// model indexed by cycles since reset release.
module tb_bounce_gen;

  localparam int unsigned MG   = 2;
  localparam int unsigned GB   = 2;
  localparam int unsigned NB   = 2;
  localparam int unsigned NE   = 2 * NB + 1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc;
  int   last_t [NE];
  int   ref_t  [NE];

  bounce_gen_if if_b ();
  bounce_gen_if if_c ();

  bounce_gen #(.MIN_GAP(MG), .GAP_BITS(GB), .BOUNCES(NB), .SEED(SEED)) u_bounce (
    .clk(clk), .rst(rst), .bus(if_b.slave)
  );

  bounce_gen #(.BOUNCES(0)) u_clean (
    .clk(clk), .rst(rst), .bus(if_c.slave)
  );

  always #5 clk = ~clk;

  // index of the next non-reset clock edge
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // LFSR contents seen at non-reset edge n (edge 0 sees SEED)
  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] v;
    v = SEED;
    for (int i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return v;
  endfunction

  function automatic int gap_at(input int n);
    logic [15:0] v;
    v = lfsr_at(n);
    return int'(MG) + int'(v[GB-1:0]);
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    if_b.press = 1'b0;
    if_c.press = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // mode 0: hold target; 1: jitter press during bounce; 2: flip press in settle cycle; 3: reset after edge 3
  task automatic run_seq(input string name, input logic target, input int mode);
    int exp_t [NE];
    int j0, jend, j, n_obs, busy_bad, exp_n, g;
    logic prev;
    logic [7:0] cnt0;
    j0   = cyc;
    cnt0 = if_b.edge_cnt;
    prev = if_b.btn;
    if_b.press = target;
    exp_t[0] = j0;
    for (int k = 1; k < int'(NE); k++) exp_t[k] = exp_t[k-1] + gap_at(exp_t[k-1]);
    exp_n = (mode == 3) ? 3 : int'(NE);
    jend  = (mode == 3) ? exp_t[2] : (mode == 2) ? exp_t[NE-1] : exp_t[NE-1] + 20;
    for (int k = 0; k < int'(NE); k++) last_t[k] = -1;
    n_obs = 0;
    busy_bad = 0;
    do begin
      tick;
      j = cyc - 1;
      if (if_b.btn !== prev) begin
        if (n_obs < int'(NE)) last_t[n_obs] = j;
        n_obs++;
        prev = if_b.btn;
      end
      if (if_b.busy !== ((j >= exp_t[0]) && (j < exp_t[NE-1]))) busy_bad++;
      if (mode == 1)
        if_b.press = (j < exp_t[NE-1] - 1 && $urandom_range(0, 1) == 1) ? ~target : target;
    end while (j < jend);

    checks++;
    if (n_obs !== exp_n) begin
      failures++;
      $display("FAIL %s edge count: got %0d expected %0d", name, n_obs, exp_n);
    end
    for (int k = 0; k < exp_n; k++) begin
      checks++;
      if (last_t[k] !== exp_t[k]) begin
        failures++;
        $display("FAIL %s edge%0d cycle: got %0d expected %0d", name, k + 1, last_t[k], exp_t[k]);
      end
    end
    for (int k = 1; k < exp_n; k++) begin
      g = last_t[k] - last_t[k-1];
      checks++;
      if (g < int'(MG) || g > int'(MG) + (1 << GB) - 1) begin
        failures++;
        $display("FAIL %s gap%0d range: got %0d expected %0d..%0d", name, k, g, MG, int'(MG) + (1 << GB) - 1);
      end
    end
    checks++;
    if (busy_bad !== 0) begin
      failures++;
      $display("FAIL %s busy profile: got %0d bad cycles expected 0", name, busy_bad);
    end
    checks++;
    if (if_b.edge_cnt !== 8'(cnt0 + 8'(exp_n))) begin
      failures++;
      $display("FAIL %s edge_cnt: got %0d expected %0d", name, if_b.edge_cnt, 8'(cnt0 + 8'(exp_n)));
    end
    if (mode != 3) begin
      checks++;
      if (if_b.btn !== target) begin
        failures++;
        $display("FAIL %s settled btn: got %0b expected %0b", name, if_b.btn, target);
      end
    end
    if (mode == 2) if_b.press = ~target;
    if (mode == 3) begin
      rst = 1'b1;
      tick;
      checks++;
      if ({if_b.btn, if_b.busy, if_b.edge_cnt} !== 10'd0) begin
        failures++;
        $display("FAIL %s reset outputs: got btn=%0b busy=%0b cnt=%0d expected 0 0 0", name, if_b.btn, if_b.busy, if_b.edge_cnt);
      end
      rst = 1'b0;
    end
  endtask

  task automatic test_reset;
    int bad_b, bad_c;
    do_reset;
    checks++;
    if ({if_b.btn, if_b.busy, if_b.edge_cnt, if_c.btn, if_c.busy, if_c.edge_cnt} !== 20'd0) begin
      failures++;
      $display("FAIL reset values: got b=%0b/%0b/%0d c=%0b/%0b/%0d expected all 0", if_b.btn, if_b.busy, if_b.edge_cnt, if_c.btn, if_c.busy, if_c.edge_cnt);
    end
    bad_b = 0;
    bad_c = 0;
    repeat (100) begin
      tick;
      if ({if_b.btn, if_b.busy, if_b.edge_cnt} !== 10'd0) bad_b++;
      if ({if_c.btn, if_c.busy, if_c.edge_cnt} !== 10'd0) bad_c++;
    end
    checks++;
    if (bad_b !== 0) begin
      failures++;
      $display("FAIL idle bounce dut: got %0d bad cycles expected 0", bad_b);
    end
    checks++;
    if (bad_c !== 0) begin
      failures++;
      $display("FAIL idle clean dut: got %0d bad cycles expected 0", bad_c);
    end
  endtask

  task automatic test_clean;
    logic lvl, exp_lvl;
    logic [7:0] exp_cnt;
    do_reset;
    repeat (10) tick;
    if_c.press = 1'b1;
    tick;
    checks++;
    if ({if_c.btn, if_c.busy, if_c.edge_cnt} !== {1'b1, 1'b0, 8'd1}) begin
      failures++;
      $display("FAIL clean rise: got btn=%0b busy=%0b cnt=%0d expected 1 0 1", if_c.btn, if_c.busy, if_c.edge_cnt);
    end
    repeat ($urandom_range(1, 8)) tick;
    checks++;
    if ({if_c.btn, if_c.busy, if_c.edge_cnt} !== {1'b1, 1'b0, 8'd1}) begin
      failures++;
      $display("FAIL clean hold: got btn=%0b busy=%0b cnt=%0d expected 1 0 1", if_c.btn, if_c.busy, if_c.edge_cnt);
    end
    if_c.press = 1'b0;
    tick;
    checks++;
    if ({if_c.btn, if_c.edge_cnt} !== {1'b0, 8'd2}) begin
      failures++;
      $display("FAIL clean fall: got btn=%0b cnt=%0d expected 0 2", if_c.btn, if_c.edge_cnt);
    end
    exp_lvl = 1'b0;
    exp_cnt = 8'd2;
    for (int i = 0; i < 8; i++) begin
      lvl = 1'($urandom_range(0, 1));
      if_c.press = lvl;
      tick;
      if (lvl != exp_lvl) exp_cnt = exp_cnt + 8'd1;
      exp_lvl = lvl;
      checks++;
      if ({if_c.btn, if_c.busy, if_c.edge_cnt} !== {exp_lvl, 1'b0, exp_cnt}) begin
        failures++;
        $display("FAIL clean random %0d: got btn=%0b busy=%0b cnt=%0d expected %0b 0 %0d", i, if_c.btn, if_c.busy, if_c.edge_cnt, exp_lvl, exp_cnt);
      end
    end
  endtask

  task automatic test_wrap;
    int n;
    logic [7:0] exp_cnt;
    exp_cnt = if_c.edge_cnt;
    n = 256 + int'($urandom_range(4, 40));
    for (int i = 0; i < n; i++) begin
      if_c.press = ~if_c.btn;
      tick;
      exp_cnt = exp_cnt + 8'd1;
    end
    checks++;
    if (if_c.edge_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL edge_cnt wrap: got %0d expected %0d", if_c.edge_cnt, exp_cnt);
    end
  endtask

  task automatic test_bounce;
    do_reset;
    repeat ($urandom_range(0, 30)) tick;
    run_seq("rise", 1'b1, 0);
    repeat ($urandom_range(0, 30)) tick;
    run_seq("fall", 1'b0, 0);
  endtask

  task automatic test_ignore_press;
    do_reset;
    repeat ($urandom_range(0, 30)) tick;
    run_seq("ignore", 1'b1, 1);
  endtask

  task automatic test_back_to_back;
    int end1;
    do_reset;
    repeat ($urandom_range(0, 30)) tick;
    run_seq("b2b_rise", 1'b1, 2);
    end1 = last_t[NE-1];
    run_seq("b2b_fall", 1'b0, 0);
    checks++;
    if (last_t[0] !== end1 + 1) begin
      failures++;
      $display("FAIL b2b restart cycle: got %0d expected %0d", last_t[0], end1 + 1);
    end
    checks++;
    if (if_b.edge_cnt !== 8'd10) begin
      failures++;
      $display("FAIL b2b total edges: got %0d expected 10", if_b.edge_cnt);
    end
  endtask

  task automatic test_mid_reset;
    do_reset;
    run_seq("ref", 1'b1, 0);
    ref_t = last_t;
    do_reset;
    run_seq("abort", 1'b1, 3);
    run_seq("rerun", 1'b1, 0);
    for (int k = 0; k < int'(NE); k++) begin
      checks++;
      if (last_t[k] !== ref_t[k]) begin
        failures++;
        $display("FAIL rerun repeat edge%0d: got %0d expected %0d", k + 1, last_t[k], ref_t[k]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_clean;
    test_wrap;
    test_bounce;
    test_ignore_press;
    test_back_to_back;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bounce_gen.md
# bounce_gen

Synthesizable mechanical-switch emulator: drives a button-like signal that bounces for a pseudo-random number of cycles before settling at a requested level. It is the producer side of the button-input path, and feeds the debounce block's `btn` input on-chip for hardware-in-the-loop self-test. Timing is randomized by a 16-bit LFSR, and the total bounce stays well inside the 30 ms (120000-cycle at 4 MHz) debounce window.

## Interface
- `MIN_GAP`, 200: minimum cycles between consecutive edges while bouncing; must be ≥ 1.
- `GAP_BITS`, 10: number of LFSR low bits added to `MIN_GAP`; range 1..15.
- `BOUNCES`, 4: number of spurious edge pairs per transition; edges per transition = 2·`BOUNCES`+1.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk` in 1: system clock, 4 MHz nominal.
- `rst` in 1: synchronous, active-high reset.
- `press` in 1: requested settled button level (1 = pressed).
- `btn` out 1: emulated noisy button output.
- `busy` out 1: high while a bounce sequence is in progress.
- `edge_cnt` out 8: free-running count of `btn` edges emitted, wraps at 256.

## Operation
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts left every non-reset cycle; the new bit 0 is lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
  - Never all-zero.
- Gap value: G = `MIN_GAP` + lfsr[`GAP_BITS`-1:0], sampled from the current LFSR on the cycle the gap counter is loaded. The gap counter is loaded with G-1.
- Gap counter width: ceil(log2(`MIN_GAP` + 2^`GAP_BITS`)) bits.
- Edge counter: counts edges within the current sequence, up to 2·`BOUNCES`+1.
- State STABLE:
  - `busy`=0.
  - If `press` != `btn` at a clock edge: toggle `btn` (edge 1), increment `edge_cnt`, set sequence edge count = 1.
  - If `BOUNCES`=0: stay in STABLE, giving a single clean edge.
  - Otherwise: load the gap counter and go to BOUNCE.
- State BOUNCE:
  - `busy`=1.
  - Gap counter ≠ 0: decrement.
  - Gap counter = 0: toggle `btn`, increment `edge_cnt` and the sequence count.
    - If the sequence count reaches 2·`BOUNCES`+1, go to STABLE.
    - Otherwise reload the gap counter with a fresh G-1.
- `press` is ignored during BOUNCE. After settling, the odd edge count guarantees `btn` equals the level that started the sequence. If `press` has since changed, a new sequence starts on the first STABLE cycle.
- Reset, including mid-bounce: next edge gives `btn`=0, `busy`=0, `edge_cnt`=0, LFSR=`SEED`, gap counter 0, state STABLE. The reset-induced change on `btn` is not counted.

## Timing
- Reset values: `btn`=0, `busy`=0, `edge_cnt`=0.
- Latency: `press` sampled different at clock edge k gives `btn` toggled and `edge_cnt` incremented right after edge k; `busy`=1 right after edge k when `BOUNCES`>0.
- Inter-edge spacing in BOUNCE is exactly G cycles, with G in [`MIN_GAP`, `MIN_GAP`+2^`GAP_BITS`-1], drawn independently per gap.
- `busy` falls in the same cycle as the final edge.
- Earliest next sequence start: one cycle after `busy` falls.
- Maximum sequence length: 2·`BOUNCES`·(`MIN_GAP`+2^`GAP_BITS`-1) cycles. With defaults this is 9784, which is below 120000.
- `edge_cnt` wraps 255→0 without affecting operation.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset, then hold `press`=0 for 100 cycles: `btn`=0, `busy`=0, `edge_cnt`=0 throughout.
- `BOUNCES`=0, raise `press` at cycle 10: `btn`=1 at cycle 11, `busy` stays 0, `edge_cnt`=1. Lower `press`: `btn`=0 one cycle later, `edge_cnt`=2.
- `MIN_GAP`=2, `GAP_BITS`=2, `BOUNCES`=2, raise `press`: exactly 5 `btn` edges, each gap in [2,5] and matching a reference LFSR model from `SEED`. Final `btn`=1, `busy` falls with edge 5, `edge_cnt`=5.
- Same parameters, toggle `press` 1→0→1 during BOUNCE: no extra edges mid-sequence. After settling at 1, `btn` holds at 1 and `edge_cnt` stays 5.
- Same parameters, lower `press` in the settle cycle: a new 5-edge sequence starts one cycle after `busy` falls. It ends at `btn`=0 with `edge_cnt`=10.
- Assert `rst` after edge 3 of a sequence: next cycle `btn`=0, `busy`=0, `edge_cnt`=0, LFSR=`SEED`. With `press`=1 after reset release, the edge timing repeats the first sequence exactly.
